arbitro_divisor: RTL and testbench

Round-robin arbiter and sequencer that shares one sequential signed divider among N_REQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and pulses the divider's Start. It then waits for Done and returns the quotient and remainder tagged with the requester ID over a single response handshake. It sits between the requesting datapaths and the divider instance.

---
 rtl/arbitro_divisor.sv | 192 +++++++++++++++++++
 tb/tb_arbitro_divisor.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbitro_divisor.sv
// rtl/arbitro_divisor.sv - round-robin arbiter/sequencer sharing one signed divider among N_REQ requesters
// Optional DIV_ZERO_BYPASS_EN: answer zero divisors locally without starting the divider.
module arbitro_divisor #(
    parameter int tamanyo = 32,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 80
) (
    input  logic                       CLK,
    input  logic                       RSTa,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*tamanyo-1:0]   req_num,
    input  logic [N_REQ*tamanyo-1:0]   req_den,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic [tamanyo-1:0]         rsp_coc,
    output logic [tamanyo-1:0]         rsp_res,
    output logic                       rsp_err,
    output logic                       div_start,
    output logic [tamanyo-1:0]         div_num,
    output logic [tamanyo-1:0]         div_den,
    input  logic [tamanyo-1:0]         div_coc,
    input  logic [tamanyo-1:0]         div_res,
    input  logic                       div_done,
    output logic                       busy
);

    localparam int IDW = $clog2(N_REQ);
    localparam int IW1 = IDW + 1;
    localparam int CW  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [IDW-1:0]     last_grant;
    logic [IDW-1:0]     grant_id;
    logic               grant_found;
    logic [IW1-1:0]     cand;

    logic [tamanyo-1:0] num_arr [N_REQ];
    logic [tamanyo-1:0] den_arr [N_REQ];

    logic [tamanyo-1:0] num_q;
    logic [tamanyo-1:0] den_q;
    logic [IDW-1:0]     id_q;
    logic [CW-1:0]      cnt;
    logic [tamanyo-1:0] coc_q;
    logic [tamanyo-1:0] res_q;
    logic               err_q;
    logic               timeout_hit;

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            num_arr[i] = req_num[i*tamanyo +: tamanyo];
            den_arr[i] = req_den[i*tamanyo +: tamanyo];
        end
    end

    // Search upward from the requester after the last winner, wrapping at N_REQ.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        cand        = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = {1'b0, last_grant} + IW1'(k);
            if (cand >= IW1'(N_REQ)) begin
                cand = cand - IW1'(N_REQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_id    = cand[IDW-1:0];
            end
        end
    end

    assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        div_start = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found) begin
                    // Gated by RSTa so nothing is offered while reset is held.
                    req_ready = RSTa ? (N_REQ'(1) << grant_id) : '0;
                    state_nxt = LAUNCH;
                end
            end
            LAUNCH: begin
`ifdef DIV_ZERO_BYPASS_EN
                if (den_q == '0) begin
                    state_nxt = RESP;
                end else begin
                    div_start = 1'b1;
                    state_nxt = WAIT;
                end
`else
                div_start = 1'b1;
                state_nxt = WAIT;
`endif
            end
            WAIT: begin
                if (div_done || timeout_hit) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            last_grant <= IDW'(N_REQ - 1);
            num_q      <= '0;
            den_q      <= '0;
            id_q       <= '0;
            cnt        <= '0;
            coc_q      <= '0;
            res_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        num_q      <= num_arr[grant_id];
                        den_q      <= den_arr[grant_id];
                        id_q       <= grant_id;
                        last_grant <= grant_id;
                    end
                end
                LAUNCH: begin
                    cnt <= '0;
`ifdef DIV_ZERO_BYPASS_EN
                    if (den_q == '0) begin
                        coc_q <= '1;
                        res_q <= num_q;
                        err_q <= 1'b1;
                    end
`endif
                end
                WAIT: begin
                    // A Done arriving on the last allowed cycle still beats the abort.
                    if (div_done) begin
                        coc_q <= div_coc;
                        res_q <= div_res;
                        err_q <= 1'b0;
                    end else if (timeout_hit) begin
                        coc_q <= '0;
                        res_q <= '0;
                        err_q <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_id  = id_q;
    assign rsp_coc = coc_q;
    assign rsp_res = res_q;
    assign rsp_err = err_q;
    assign div_num = num_q;
    assign div_den = den_q;
    assign busy    = (state != IDLE);

endmodule

// File: tb/tb_arbitro_divisor.sv
// tb/tb_arbitro_divisor.sv - self-checking bench for arbitro_divisor with a behavioural divider
module tb_arbitro_divisor;

    localparam int W  = 32;
    localparam int N  = 4;
    localparam int TO = 80;

    logic            CLK = 1'b0;
    logic            RSTa = 1'b0;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*W-1:0]  req_num = '0;
    logic [N*W-1:0]  req_den = '0;
    logic            rsp_valid;
    logic            rsp_ready = 1'b1;
    logic [1:0]      rsp_id;
    logic [W-1:0]    rsp_coc;
    logic [W-1:0]    rsp_res;
    logic            rsp_err;
    logic            div_start;
    logic [W-1:0]    div_num;
    logic [W-1:0]    div_den;
    logic [W-1:0]    div_coc;
    logic [W-1:0]    div_res;
    logic            div_done;
    logic            busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    arbitro_divisor #(.tamanyo(W), .N_REQ(N), .TIMEOUT(TO)) dut (
        .CLK(CLK), .RSTa(RSTa),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_num(req_num), .req_den(req_den),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_coc(rsp_coc), .rsp_res(rsp_res), .rsp_err(rsp_err),
        .div_start(div_start), .div_num(div_num), .div_den(div_den),
        .div_coc(div_coc), .div_res(div_res), .div_done(div_done),
        .busy(busy)
    );

    // Behavioural divider: Done observed m_lat+2 edges after the Start edge.
    int                  m_lat = 5;
    bit                  never_done = 1'b0;
    logic                m_busy;
    int                  m_cnt;
    logic signed [W-1:0] m_num;
    logic signed [W-1:0] m_den;

    always @(posedge CLK or negedge RSTa) begin
        if (!RSTa) begin
            m_busy   <= 1'b0;
            m_cnt    <= 0;
            m_num    <= '0;
            m_den    <= '0;
            div_done <= 1'b0;
            div_coc  <= '0;
            div_res  <= '0;
        end else begin
            div_done <= 1'b0;
            if (div_start) begin
                m_busy <= 1'b1;
                m_cnt  <= m_lat;
                m_num  <= div_num;
                m_den  <= div_den;
            end else if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy <= 1'b0;
                    if (!never_done) begin
                        div_done <= 1'b1;
                        if (m_den == 0) begin
                            div_coc <= '1;
                            div_res <= m_num;
                        end else begin
                            div_coc <= m_num / m_den;
                            div_res <= m_num % m_den;
                        end
                    end
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    int          cyc = 0;
    int          n_start, start_edge, done_edge, first_rv_edge;
    bit          rv_prev = 1'b0;
    int          grant_q[$];
    int          grant_edge_q[$];
    int          rsp_id_q[$];
    logic [W-1:0] rsp_coc_q[$];
    logic [W-1:0] rsp_res_q[$];
    bit          rsp_err_q[$];
    int          rsp_edge_q[$];

    always @(posedge CLK) begin
        cyc++;
        if (div_start) begin
            n_start++;
            start_edge = cyc;
        end
        if (div_done) done_edge = cyc;
        if (rsp_valid && !rv_prev) first_rv_edge = cyc;
        rv_prev = rsp_valid;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                grant_q.push_back(i);
                grant_edge_q.push_back(cyc);
            end
        end
        if (rsp_valid && rsp_ready) begin
            rsp_id_q.push_back(int'(rsp_id));
            rsp_coc_q.push_back(rsp_coc);
            rsp_res_q.push_back(rsp_res);
            rsp_err_q.push_back(rsp_err);
            rsp_edge_q.push_back(cyc);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_log();
        n_start = 0; start_edge = -1000; done_edge = -1000; first_rv_edge = -1000;
        grant_q.delete(); grant_edge_q.delete();
        rsp_id_q.delete(); rsp_coc_q.delete(); rsp_res_q.delete();
        rsp_err_q.delete(); rsp_edge_q.delete();
    endtask

    task automatic wait_grants(input string name, input int n, input int budget);
        int i = 0;
        while (grant_q.size() < n && i < budget) begin
            step();
            i++;
        end
        check({name, "_grant_seen"}, 128'(grant_q.size() >= n), 128'd1);
    endtask

    task automatic wait_rsps(input string name, input int n, input int budget);
        int i = 0;
        while (rsp_id_q.size() < n && i < budget) begin
            step();
            i++;
        end
        check({name, "_rsp_seen"}, 128'(rsp_id_q.size() >= n), 128'd1);
    endtask

    task automatic set_req(input int r, input logic [W-1:0] num, input logic [W-1:0] den);
        req_num[r*W +: W] = num;
        req_den[r*W +: W] = den;
    endtask

    task automatic check_rsp(input string name, input int k, input int id,
                             input logic [W-1:0] coc, input logic [W-1:0] res, input bit err);
        if (rsp_id_q.size() > k) begin
            check({name, "_id"},  128'(rsp_id_q[k]),  128'(id));
            check({name, "_coc"}, 128'(rsp_coc_q[k]), 128'(coc));
            check({name, "_res"}, 128'(rsp_res_q[k]), 128'(res));
            check({name, "_err"}, 128'(rsp_err_q[k]), 128'(err));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check(name, {req_ready, rsp_valid, rsp_id, rsp_coc, rsp_res, rsp_err,
                     div_start, div_num, div_den, busy}, 128'd0);
    endtask

    typedef struct {
        int          req;
        logic [W-1:0] num;
        logic [W-1:0] den;
        logic [W-1:0] coc;
        logic [W-1:0] res;
        bit          err;
        int          starts;
    } vec_t;

    vec_t vecs [5];

    initial begin
        int   g_edge;
        int   bad;
        int   exp_rr [4];

        vecs[0] = '{0, 32'd100,  32'd7,   32'd14,         32'd2,          1'b0, 1};
        vecs[1] = '{2, -32'sd100, 32'd7,  -32'sd14,       -32'sd2,        1'b0, 1};
        vecs[2] = '{1, 32'd7,    32'd100, 32'd0,          32'd7,          1'b0, 1};
        vecs[3] = '{3, -32'sd50, -32'sd8, 32'd6,          -32'sd2,        1'b0, 1};
`ifdef DIV_ZERO_BYPASS_EN
        vecs[4] = '{2, 32'd55,   32'd0,   32'hFFFF_FFFF,  32'd55,         1'b1, 0};
`else
        vecs[4] = '{2, 32'd55,   32'd0,   32'hFFFF_FFFF,  32'd55,         1'b0, 1};
`endif
        exp_rr[0] = 0; exp_rr[1] = 1; exp_rr[2] = 3; exp_rr[3] = 0;

        clear_log();
        req_valid = 4'b1111;
        step();
        step();
        check_reset_outputs("reset_state");
        req_valid = '0;
        RSTa = 1'b1;
        step();

        for (int v = 0; v < 5; v++) begin
            clear_log();
            set_req(vecs[v].req, vecs[v].num, vecs[v].den);
            req_valid = N'(1) << vecs[v].req;
            wait_grants($sformatf("v%0d", v), 1, 50);
            req_valid = '0;
            wait_rsps($sformatf("v%0d", v), 1, 200);
            check_rsp($sformatf("v%0d", v), 0, vecs[v].req, vecs[v].coc, vecs[v].res, vecs[v].err);
            check($sformatf("v%0d_starts", v), 128'(n_start), 128'(vecs[v].starts));
            g_edge = (grant_edge_q.size() > 0) ? grant_edge_q[0] : -2000;
            if (vecs[v].starts == 1) begin
                check($sformatf("v%0d_start_lat", v), 128'(start_edge - g_edge), 128'd1);
                check($sformatf("v%0d_rsp_lat", v), 128'(first_rv_edge - done_edge), 128'd1);
            end else begin
                check($sformatf("v%0d_bypass_lat", v), 128'(first_rv_edge - g_edge), 128'd2);
            end
        end

        // Round-robin from a fresh reset: 0, 1, 3, 0
        RSTa = 1'b0;
        step();
        RSTa = 1'b1;
        clear_log();
        for (int r = 0; r < N; r++) set_req(r, 32'd20, -32'sd3);
        req_valid = 4'b1011;
        wait_rsps("rr", 4, 400);
        req_valid = '0;
        check("rr_grant_count", 128'(grant_q.size()), 128'd4);
        for (int i = 0; i < 4; i++) begin
            if (grant_q.size() > i)
                check($sformatf("rr_grant%0d", i), 128'(grant_q[i]), 128'(exp_rr[i]));
            check_rsp($sformatf("rr_rsp%0d", i), i, exp_rr[i], -32'sd6, 32'd2, 1'b0);
        end

        // Backpressure: hold response, requester 2 pending
        clear_log();
        rsp_ready = 1'b0;
        set_req(1, 32'd9, 32'd2);
        set_req(2, 32'd8, 32'd3);
        req_valid = 4'b0110;
        wait_grants("bp1", 1, 50);
        req_valid = 4'b0100;
        bad = 0;
        while (!rsp_valid && bad < 200) begin
            step();
            bad++;
        end
        check("bp_rsp_valid", 128'(rsp_valid), 128'd1);
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (!(rsp_valid && rsp_id == 2'd1 && rsp_coc == 32'd4 && rsp_res == 32'd1 &&
                  !rsp_err && req_ready == '0 && n_start == 1 && busy)) bad++;
            step();
        end
        check("bp_hold_bad_cycles", 128'(bad), 128'd0);
        rsp_ready = 1'b1;
        wait_grants("bp2", 2, 50);
        req_valid = '0;
        if (grant_q.size() > 1 && rsp_edge_q.size() > 0) begin
            check("bp_next_grant_id", 128'(grant_q[1]), 128'd2);
            check("bp_next_grant_edge", 128'(grant_edge_q[1] - rsp_edge_q[0]), 128'd1);
        end
        wait_rsps("bp", 2, 200);
        check_rsp("bp_first", 0, 1, 32'd4, 32'd1, 1'b0);
        check_rsp("bp_second", 1, 2, 32'd2, 32'd2, 1'b0);

        // Timeout: divider never answers
        clear_log();
        never_done = 1'b1;
        set_req(0, 32'd1, 32'd1);
        req_valid = 4'b0001;
        wait_grants("to", 1, 50);
        req_valid = '0;
        wait_rsps("to", 1, 200);
        check_rsp("to", 0, 0, 32'd0, 32'd0, 1'b1);
        check("to_lat", 128'(first_rv_edge - start_edge), 128'd81);
        check("to_starts", 128'(n_start), 128'd1);
        never_done = 1'b0;

        // Done on the last allowed WAIT cycle wins over the abort
        clear_log();
        m_lat = 78;
        set_req(3, 32'd77, 32'd10);
        req_valid = 4'b1000;
        wait_grants("edge", 1, 50);
        req_valid = '0;
        wait_rsps("edge", 1, 200);
        check("edge_done_at", 128'(done_edge - start_edge), 128'd80);
        check("edge_lat", 128'(first_rv_edge - start_edge), 128'd81);
        check_rsp("edge", 0, 3, 32'd7, 32'd7, 1'b0);

        // Reset during WAIT: no response, requester 0 first afterwards
        clear_log();
        m_lat = 30;
        set_req(2, 32'd10, 32'd3);
        req_valid = 4'b0100;
        wait_grants("rw", 1, 50);
        req_valid = '0;
        bad = 0;
        while (n_start == 0 && bad < 50) begin
            step();
            bad++;
        end
        step(); step(); step();
        check("rw_in_wait_busy", 128'(busy), 128'd1);
        set_req(0, 32'd50, 32'd5);
        set_req(3, 32'd1, 32'd1);
        req_valid = 4'b1001;
        RSTa = 1'b0;
        #1;
        check_reset_outputs("rw_reset_outputs");
        step();
        RSTa = 1'b1;
        m_lat = 5;
        clear_log();
        wait_grants("rw", 1, 50);
        if (grant_q.size() > 0) check("rw_first_grant", 128'(grant_q[0]), 128'd0);
        req_valid = '0;
        wait_rsps("rw", 1, 200);
        for (int i = 0; i < 40; i++) step();
        check("rw_rsp_count", 128'(rsp_id_q.size()), 128'd1);
        check_rsp("rw", 0, 0, 32'd10, 32'd0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
